// File: rtl/encrypt_pkg.sv
// Shared widths, FSM encoding and round-key step
// for the round_sequencer slice.
package encrypt_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 32;
    localparam logic [KEY_W-1:0] RC_DEFAULT = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    function automatic logic [KEY_W-1:0] next_rk(
        input logic [KEY_W-1:0] rk,
        input logic [KEY_W-1:0] rc = RC_DEFAULT
    );
        return {rk[KEY_W-2:0], rk[KEY_W-1]} ^ rc;
    endfunction

endpackage

// File: rtl/round_key_gen.sv
// Round-key register: loaded with the block key on
// acceptance, stepped once per completed round.
module round_key_gen
    import encrypt_pkg::*;
#(
    parameter logic [KEY_W-1:0] RC = RC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] rk
);

    logic [KEY_W-1:0] rk_q;
    logic [KEY_W-1:0] rk_d;

    always_comb begin
        rk_d = rk_q;
        if (load) begin
            rk_d = key;
        end else if (advance) begin
            rk_d = next_rk(rk_q, RC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_q <= '0;
        end else begin
            rk_q <= rk_d;
        end
    end

    assign rk = rk_q;

endmodule

// File: rtl/round_sequencer.sv
// Bounded, handshaked driver for a shared single-round
// datapath: one block in, NUM_ROUNDS rounds, one block out.
module round_sequencer
    import encrypt_pkg::*;
#(
    parameter int unsigned      NUM_ROUNDS = 16,
    parameter int unsigned      ROUND_LAT  = 1,
    parameter logic [KEY_W-1:0] RC         = RC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] in,
    input  logic               read,
    output logic               ready,
    output logic [BLOCK_W-1:0] out,
    output logic               write,
    output logic [BLOCK_W-1:0] rnd_in,
    output logic [KEY_W-1:0]   rnd_key,
    input  logic [BLOCK_W-1:0] rnd_out,
    output logic [7:0]         round_idx
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255) begin : g_bad_rounds
        $error("round_sequencer: NUM_ROUNDS must be 1..255");
    end
    if (ROUND_LAT < 1 || ROUND_LAT > 7) begin : g_bad_lat
        $error("round_sequencer: ROUND_LAT must be 1..7");
    end

    localparam logic [7:0] LAST_IDX  = 8'(NUM_ROUNDS - 1);
    localparam logic [2:0] WAIT_INIT = 3'(ROUND_LAT - 1);

    state_e             fsm_q, fsm_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic [7:0]         idx_q, idx_d;
    logic [2:0]         wait_q, wait_d;
    logic               rk_load;
    logic               rk_adv;
    logic [KEY_W-1:0]   rk;
    logic [BLOCK_W-1:0] mixed;
    logic               wait_done;
    logic               last_round;

    assign mixed      = rnd_out ^ {4{rk}};
    assign wait_done  = (wait_q == 3'd0);
    assign last_round = (idx_q == LAST_IDX);

    round_key_gen #(
        .RC(RC)
    ) u_rkg (
        .clk    (clk),
        .rst    (rst),
        .load   (rk_load),
        .advance(rk_adv),
        .key    (key),
        .rk     (rk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            out_q  <= '0;
            idx_q  <= '0;
            wait_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            out_q  <= out_d;
            idx_q  <= idx_d;
            wait_q <= wait_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (read) fsm_d = ISSUE;
            ISSUE:   fsm_d = WAIT;
            WAIT: begin
                if (wait_done) begin
                    fsm_d = last_round ? DONE : ISSUE;
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // State, counters and key only move on the edges the FSM names.
    always_comb begin
        blk_d   = blk_q;
        out_d   = out_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        rk_load = 1'b0;
        rk_adv  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (read) begin
                    blk_d   = in;
                    idx_d   = '0;
                    rk_load = 1'b1;
                end
            end
            ISSUE: wait_d = WAIT_INIT;
            WAIT: begin
                if (!wait_done) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    blk_d  = mixed;
                    rk_adv = 1'b1;
                    if (last_round) begin
                        out_d = mixed;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            DONE:    idx_d = '0;
            default: idx_d = '0;
        endcase
    end

    always_comb begin
        ready = (fsm_q == IDLE);
        write = (fsm_q == DONE);
    end

    assign out       = out_q;
    assign rnd_in    = blk_q;
    assign rnd_key   = rk;
    assign round_idx = idx_q;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Control FSM that runs one 128-bit block through a shared single-round datapath (pre-mix, p-box, registered s-boxes, p-box, rotations) for NUM_ROUNDS iterations.
- Owns the state register, round counter and round-key schedule, and applies the round key after each round.
- Accepts a block and key on a read strobe and returns the result on a one-cycle write strobe.
- Replaces the free-running loop with a bounded, handshaked sequence.

Parameters:
- NUM_ROUNDS, 16, rounds per block; legal range 1..255.
- ROUND_LAT, 1, clock cycles from rnd_in stable to rnd_out valid (1 = registered s-box stage); legal range 1..7.
- RC, 32'h9E3779B9, round-key schedule constant.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key  in  32  block key; sampled only at acceptance
- in  in  128  plaintext block; sampled only at acceptance
- read  in  1  request strobe; accepted when read && ready
- ready  out  1  high in IDLE only
- out  out  128  result block; registered, held until next completion
- write  out  1  one-cycle completion strobe, coincident with new out
- rnd_in  out  128  state presented to the datapath
- rnd_key  out  32  current round key, for observability
- rnd_out  in  128  datapath result
- round_idx  out  8  current round number 0..NUM_ROUNDS-1; 0 when idle

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, ready=1, write=0, out=0, rnd_in=0, rnd_key=0, round_idx=0, wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ready=1.
  - On read: state<=in, rk<=key, round_idx<=0, go ISSUE.
  - The acceptance edge is E0.
- ISSUE: one cycle; rnd_in=state, which is already stable; go WAIT, load wait counter with ROUND_LAT-1.
- WAIT:
  - Holds rnd_in steady; stays until the wait counter reaches 0, for ROUND_LAT cycles in total.
  - On the final WAIT edge, capture state <= rnd_out ^ {4{rk}}.
  - Advance rk <= {rk[30:0],rk[31]} ^ RC.
  - If round_idx==NUM_ROUNDS-1: out<=captured value, go DONE. Otherwise round_idx++, go ISSUE.
- Round timing: each round takes exactly ROUND_LAT+1 cycles. rnd_in must not change within a round.
- DONE: write=1 and ready=0 for exactly one cycle, then IDLE.
- Latency: the final capture edge is E0+NUM_ROUNDS*(ROUND_LAT+1). write is high in the cycle following that edge.
- Throughput: with read held high, blocks are accepted every NUM_ROUNDS*(ROUND_LAT+1)+2 cycles.
- read while not IDLE (ISSUE/WAIT/DONE): ignored, not queued, no side effects.
- key and in changing mid-run: no effect.
- rst mid-run: abort immediately to the reset values. No write for the aborted block; out is cleared to 0.
- rst and read in the same cycle: rst wins; the block is not accepted.
- Widths: rk is 32 bits and rotation is modulo 32. round_idx is 8 bits and never wraps, because NUM_ROUNDS≤255.
- Out of range: an elaboration-time error for NUM_ROUNDS=0 or ROUND_LAT=0.

Decomposition:
- Package encrypt_pkg:
  - BLOCK_W=128, KEY_W=32, RC_DEFAULT.
  - State enum {IDLE,ISSUE,WAIT,DONE}.
  - Function next_rk(rk).
- Sub-module round_key_gen (clk, rst, load, advance, key, rk): holds and advances the round key. The FSM, wait counter and state register stay in round_sequencer.

Test Plan:
- Reset check: assert rst 3 cycles with read=1 → ready=1, write=0, out=0, round_idx=0 throughout; no acceptance.
- Identity stub (rnd_out = rnd_in delayed one register), NUM_ROUNDS=1, ROUND_LAT=1, in=0, key=32'h01234567:
  - write high in the cycle after edge E0+2.
  - out={4{32'h01234567}}.
- Same stub, NUM_ROUNDS=2, in=0, key=0:
  - rk1=32'h9E3779B9, so out={4{32'h9E3779B9}}.
  - write after edge E0+4.
  - round_idx shows 0 then 1.
- Defaults (16 rounds, ROUND_LAT=1), read held high for 100 cycles:
  - accepts at E0, E0+34, E0+68.
  - Exactly 3 write pulses, each one cycle.
  - ready low between accepts except in IDLE.
  - in changes while busy do not affect out.
- ROUND_LAT=3, NUM_ROUNDS=4:
  - rnd_in constant for 4 consecutive cycles per round.
  - write after edge E0+16.
- Mid-run abort: assert rst at E0+10 for one cycle → no write, out=0, ready=1 next cycle. A new read then completes normally with the expected value.
